// File: rtl/elevator_plant_model.sv
// Cycle-level plant model of an elevator cab and its door.
// It turns engine and door commands into position, sensors and a sticky fault.
module elevator_plant_model #(
    parameter int unsigned FLOORS       = 8,
    parameter int unsigned FLOOR_W      = 3,
    parameter int unsigned DELAY_ENGINE = 10,
    parameter int unsigned DELAY_DOOR   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         engine,
    input  logic [1:0]         door,
    input  logic               obstruct,
    output logic [FLOOR_W-1:0] floor_pos,
    output logic [FLOORS-1:0]  sensor_floor,
    output logic [1:0]         sensor_door,
    output logic               moving,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam int unsigned OFF_W  = $clog2(DELAY_ENGINE);
    localparam int unsigned DOOR_W = $clog2(DELAY_DOOR + 1);

    localparam logic [OFF_W-1:0]   OFF_MAX  = OFF_W'(DELAY_ENGINE - 1);
    localparam logic [DOOR_W-1:0]  DOOR_MAX = DOOR_W'(DELAY_DOOR);
    localparam logic [FLOOR_W-1:0] TOP      = FLOOR_W'(FLOORS - 1);

    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_OVER  = 2'd1;
    localparam logic [1:0] CODE_INTLK = 2'd2;
    localparam logic [1:0] CODE_MISAL = 2'd3;

    typedef enum logic [2:0] {
        StClosed,
        StOpening,
        StOpen,
        StClosing,
        StStopped
    } door_state_e;

    logic [FLOOR_W-1:0] r_floor,      w_floor_d;
    logic [OFF_W-1:0]   r_offset,     w_offset_d;
    logic [DOOR_W-1:0]  r_door_cnt,   w_door_cnt_d;
    door_state_e        r_door_state, w_door_state_d;
    logic               r_moving,     w_moving_d;
    logic               r_fault,      w_fault_d;
    logic [1:0]         r_fault_code, w_fault_code_d;

    logic w_eng_up;
    logic w_eng_dn;
    logic w_door_open;
    logic w_door_close;
    logic w_interlock;
    logic w_overtravel;
    logic w_misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_floor      <= '0;
            r_offset     <= '0;
            r_door_cnt   <= '0;
            r_door_state <= StClosed;
            r_moving     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= CODE_NONE;
        end else begin
            r_floor      <= w_floor_d;
            r_offset     <= w_offset_d;
            r_door_cnt   <= w_door_cnt_d;
            r_door_state <= w_door_state_d;
            r_moving     <= w_moving_d;
            r_fault      <= w_fault_d;
            r_fault_code <= w_fault_code_d;
        end
    end

    // Obstruction turns a close into an open; an open at full travel just holds.
    always_comb begin
        w_eng_up     = (engine == 2'd2);
        w_eng_dn     = (engine == 2'd1);
        w_door_open  = (door == 2'd1) || ((door == 2'd2) && obstruct);
        w_door_close = (door == 2'd2) && !obstruct;
        w_interlock  = (w_eng_up || w_eng_dn) && (r_door_cnt != '0);
        w_overtravel = (w_eng_up && (r_floor == TOP) && (r_offset == '0)) ||
                       (w_eng_dn && (r_floor == '0) && (r_offset == '0));
        w_misaligned = w_door_open && (r_offset != '0);
    end

    always_comb begin
        w_floor_d      = r_floor;
        w_offset_d     = r_offset;
        w_door_cnt_d   = r_door_cnt;
        w_door_state_d = r_door_state;
        w_moving_d     = 1'b0;
        w_fault_d      = r_fault;
        w_fault_code_d = r_fault_code;

        if (r_fault) begin
            // Frozen until reset.
        end else if (w_interlock || w_overtravel || w_misaligned) begin
            w_fault_d = 1'b1;
            if (w_interlock) begin
                w_fault_code_d = CODE_INTLK;
            end else if (w_overtravel) begin
                w_fault_code_d = CODE_OVER;
            end else begin
                w_fault_code_d = CODE_MISAL;
            end
        end else begin
            if (w_eng_up) begin
                w_moving_d = 1'b1;
                if (r_offset == OFF_MAX) begin
                    w_offset_d = '0;
                    w_floor_d  = r_floor + FLOOR_W'(1);
                end else begin
                    w_offset_d = r_offset + OFF_W'(1);
                end
            end else if (w_eng_dn) begin
                w_moving_d = 1'b1;
                if (r_offset == '0) begin
                    w_offset_d = OFF_MAX;
                    w_floor_d  = r_floor - FLOOR_W'(1);
                end else begin
                    w_offset_d = r_offset - OFF_W'(1);
                end
            end

            if (w_door_open && (r_door_cnt != DOOR_MAX)) begin
                w_door_cnt_d = r_door_cnt + DOOR_W'(1);
            end else if (w_door_close && (r_door_cnt != '0)) begin
                w_door_cnt_d = r_door_cnt - DOOR_W'(1);
            end

            if (w_door_cnt_d == '0) begin
                w_door_state_d = StClosed;
            end else if (w_door_cnt_d == DOOR_MAX) begin
                w_door_state_d = StOpen;
            end else if (w_door_open) begin
                w_door_state_d = StOpening;
            end else if (w_door_close) begin
                w_door_state_d = StClosing;
            end else begin
                w_door_state_d = StStopped;
            end
        end
    end

    always_comb begin
        sensor_floor = '0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            sensor_floor[i] = (r_offset == '0) && (r_floor == FLOOR_W'(i));
        end
        unique case (r_door_state)
            StClosed: sensor_door = 2'd2;
            StOpen:   sensor_door = 2'd1;
            default:  sensor_door = 2'd0;
        endcase
    end

    assign floor_pos  = r_floor;
    assign moving     = r_moving;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule

// File: tb/tb_elevator_plant_model.sv
// Bench for elevator_plant_model: directed vector table, corner sequences, and
// random traffic checked against a linear-position reference model.
module tb_elevator_plant_model;

    localparam int F  = 4;
    localparam int FW = 2;
    localparam int DE = 4;
    localparam int DD = 3;

    logic          clk;
    logic          reset;
    logic [1:0]    engine;
    logic [1:0]    door;
    logic          obstruct;
    logic [FW-1:0] floor_pos;
    logic [F-1:0]  sensor_floor;
    logic [1:0]    sensor_door;
    logic          moving;
    logic          fault;
    logic [1:0]    fault_code;

    elevator_plant_model #(
        .FLOORS      (F),
        .FLOOR_W     (FW),
        .DELAY_ENGINE(DE),
        .DELAY_DOOR  (DD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .engine      (engine),
        .door        (door),
        .obstruct    (obstruct),
        .floor_pos   (floor_pos),
        .sensor_floor(sensor_floor),
        .sensor_door (sensor_door),
        .moving      (moving),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference: cab as one linear position floor*DE+offset, door as a plain count.
    int m_pos;
    int m_door;
    int m_moving;
    int m_fault;
    int m_code;

    typedef struct {
        logic [1:0] eng;
        logic [1:0] dr;
        logic       obs;
        logic [1:0] fl;
        logic [3:0] sf;
        logic [1:0] sd;
        logic       mv;
        logic       flt;
        logic [1:0] code;
    } vec_t;

    vec_t vecs[23];

    task automatic model_reset();
        m_pos = 0; m_door = 0; m_moving = 0; m_fault = 0; m_code = 0;
    endtask

    task automatic model_step(input logic [1:0] e, input logic [1:0] d, input logic o);
        bit up, dn, op, cl, il, ot, mis;
        int prev;
        up   = (e == 2'd2);
        dn   = (e == 2'd1);
        op   = (d == 2'd1) || ((d == 2'd2) && o);
        cl   = (d == 2'd2) && !o;
        prev = m_pos;
        m_moving = 0;
        if (m_fault != 0) return;
        il  = (up || dn) && (m_door != 0);
        ot  = (up && (m_pos == (F - 1) * DE)) || (dn && (m_pos == 0));
        mis = op && ((m_pos % DE) != 0);
        if (il || ot || mis) begin
            m_fault = 1;
            m_code  = il ? 2 : (ot ? 1 : 3);
            return;
        end
        if (up) m_pos++;
        if (dn) m_pos--;
        if (op && m_door < DD) m_door++;
        if (cl && m_door > 0) m_door--;
        m_moving = (m_pos != prev) ? 1 : 0;
    endtask

    task automatic check(input string name, input logic [1:0] fl, input logic [3:0] sf,
                         input logic [1:0] sd, input logic mv, input logic flt,
                         input logic [1:0] code);
        checks++;
        if ({floor_pos, sensor_floor, sensor_door, moving, fault, fault_code} !==
            {fl, sf, sd, mv, flt, code}) begin
            errors++;
            $display("FAIL %s @%0t: got floor=%0d sf=%b sd=%0d mv=%0d fault=%0d code=%0d; want floor=%0d sf=%b sd=%0d mv=%0d fault=%0d code=%0d",
                     name, $time, floor_pos, sensor_floor, sensor_door, moving, fault,
                     fault_code, fl, sf, sd, mv, flt, code);
        end
    endtask

    task automatic check_model(input string name);
        logic [1:0] fl;
        logic [3:0] sf;
        logic [1:0] sd;
        fl = 2'(m_pos / DE);
        sf = ((m_pos % DE) == 0) ? 4'(1 << (m_pos / DE)) : 4'b0000;
        sd = (m_door == 0) ? 2'd2 : ((m_door == DD) ? 2'd1 : 2'd0);
        check(name, fl, sf, sd, m_moving[0], m_fault[0], 2'(m_code));
    endtask

    task automatic step(input logic [1:0] e, input logic [1:0] d, input logic o);
        @(negedge clk);
        engine   = e;
        door     = d;
        obstruct = o;
        @(posedge clk);
        model_step(e, d, o);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        engine = 2'd0; door = 2'd0; obstruct = 1'b0;
        reset  = 1'b0;
        model_reset();
        #1 check("reset", 2'd0, 4'b0001, 2'd2, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; engine = 2'd0; door = 2'd0; obstruct = 1'b0;
        model_reset();

        vecs[0]  = '{2'd2, 2'd0, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{2'd2, 2'd0, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b1, 1'b0, 2'd0};
        vecs[2]  = '{2'd2, 2'd0, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b1, 1'b0, 2'd0};
        vecs[3]  = '{2'd2, 2'd0, 1'b0, 2'd1, 4'b0010, 2'd2, 1'b1, 1'b0, 2'd0};
        vecs[4]  = '{2'd2, 2'd0, 1'b0, 2'd1, 4'b0000, 2'd2, 1'b1, 1'b0, 2'd0};
        vecs[5]  = '{2'd2, 2'd0, 1'b0, 2'd1, 4'b0000, 2'd2, 1'b1, 1'b0, 2'd0};
        vecs[6]  = '{2'd1, 2'd0, 1'b0, 2'd1, 4'b0000, 2'd2, 1'b1, 1'b0, 2'd0};
        vecs[7]  = '{2'd1, 2'd0, 1'b0, 2'd1, 4'b0010, 2'd2, 1'b1, 1'b0, 2'd0};
        vecs[8]  = '{2'd0, 2'd0, 1'b0, 2'd1, 4'b0010, 2'd2, 1'b0, 1'b0, 2'd0};
        vecs[9]  = '{2'd0, 2'd1, 1'b0, 2'd1, 4'b0010, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[10] = '{2'd0, 2'd1, 1'b0, 2'd1, 4'b0010, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[11] = '{2'd0, 2'd1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{2'd0, 2'd2, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b0, 2'd0};
        vecs[13] = '{2'd0, 2'd2, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b0, 2'd0};
        vecs[14] = '{2'd0, 2'd2, 1'b0, 2'd1, 4'b0010, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[15] = '{2'd0, 2'd2, 1'b0, 2'd1, 4'b0010, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[16] = '{2'd0, 2'd2, 1'b0, 2'd1, 4'b0010, 2'd2, 1'b0, 1'b0, 2'd0};
        vecs[17] = '{2'd0, 2'd1, 1'b0, 2'd1, 4'b0010, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[18] = '{2'd0, 2'd1, 1'b0, 2'd1, 4'b0010, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[19] = '{2'd0, 2'd1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b0, 2'd0};
        vecs[20] = '{2'd2, 2'd0, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b1, 2'd2};
        vecs[21] = '{2'd2, 2'd2, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b1, 2'd2};
        vecs[22] = '{2'd1, 2'd1, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b1, 2'd2};

        do_reset();
        for (int i = 0; i < 23; i++) begin
            step(vecs[i].eng, vecs[i].dr, vecs[i].obs);
            check($sformatf("vec%0d", i), vecs[i].fl, vecs[i].sf, vecs[i].sd, vecs[i].mv,
                  vecs[i].flt, vecs[i].code);
        end

        // Overtravel at the top floor, then frozen.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(2'd2, 2'd0, 1'b0);
            check_model("climb");
        end
        check("at_top", 2'd3, 4'b1000, 2'd2, 1'b1, 1'b0, 2'd0);
        step(2'd2, 2'd0, 1'b0);
        check("overtravel", 2'd3, 4'b1000, 2'd2, 1'b0, 1'b1, 2'd1);
        step(2'd1, 2'd1, 1'b0);
        check("overtravel_hold", 2'd3, 4'b1000, 2'd2, 1'b0, 1'b1, 2'd1);

        // Door open while between floors.
        do_reset();
        step(2'd2, 2'd0, 1'b0);
        step(2'd2, 2'd0, 1'b0);
        step(2'd0, 2'd1, 1'b0);
        check("misaligned", 2'd0, 4'b0000, 2'd2, 1'b0, 1'b1, 2'd3);

        // Interlock outranks overtravel (down at floor 0 with door ajar).
        do_reset();
        step(2'd0, 2'd1, 1'b0);
        check("door_ajar", 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0, 2'd0);
        step(2'd1, 2'd0, 1'b0);
        check("priority", 2'd0, 4'b0001, 2'd0, 1'b0, 1'b1, 2'd2);

        // Asynchronous reset mid-travel at floor 2, offset 2.
        do_reset();
        for (int i = 0; i < 10; i++) step(2'd2, 2'd0, 1'b0);
        check("mid_travel", 2'd2, 4'b0000, 2'd2, 1'b1, 1'b0, 2'd0);
        #2;
        reset = 1'b0;
        model_reset();
        #1 check("async_reset", 2'd0, 4'b0001, 2'd2, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        engine = 2'd0;
        reset  = 1'b1;

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] e, d;
            logic       o;
            if (m_fault != 0 && $urandom_range(3) == 0) begin
                do_reset();
            end
            if (m_door != 0) e = ($urandom_range(15) == 0) ? 2'($urandom_range(3)) : 2'd0;
            else             e = 2'($urandom_range(3));
            if ((m_pos % DE) != 0)
                d = ($urandom_range(15) == 0) ? 2'($urandom_range(3)) : 2'd0;
            else
                d = ($urandom_range(2) == 0) ? 2'd0 : 2'($urandom_range(3));
            o = ($urandom_range(3) == 0);
            step(e, d, o);
            check_model("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
